// File: rtl/multu_sequencer_pkg.sv
// Shared CPU decode constants and the MULTU sequencer state encoding.
package cpu_defs;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/multu_shift_add_step.sv
// One radix-2 shift-add multiply step: conditionally add the multiplicand into
// the upper half, then shift the whole accumulator right with the carry.
module multu_shift_add_step
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  assign addend = acc_i[0] ? mcand_i : {WIDTH{1'b0}};
  // The WIDTH+1 sum keeps the carry, which becomes the new MSB after the shift.
  assign sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_o  = {sum, acc_i[WIDTH-1:1]};

endmodule

// File: rtl/multu_sequencer.sv
// Multi-cycle MULTU sequencer owning HI/LO; stalls HI/LO readers and a second
// MULTU while a multiply is still running.
module multu_sequencer
  import cpu_defs::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_step;

  multu_shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          acc_d   = {{WIDTH{1'b0}}, OpB};
          mcand_d = OpA;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A Start arriving here is stalled and ignored; the pipeline re-presents it.
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          lo_d    = acc_step[WIDTH-1:0];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy  = (state_q == RUN);
  assign Stall = Busy & (HiLoRead | Start);
  assign Done  = (state_q == DONE);
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule
